multicycle_control_fsm: RTL and testbench

//   Main controller for the multicycle RISC-V datapath. Replaces the hand-driven control

---
 rtl/multicycle_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V main controller: sequences lw/sw/R/I/beq/jal through
// FETCH..WB states and drives datapath selects and write enables.
module multicycle_control_fsm #(
  parameter int STATE_WIDTH   = 4,
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7b5,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   AdrSrc,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic [1:0]             ResultSrc,
  output logic [1:0]             ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUControl,
  output logic [1:0]             ImmSrc,
  output logic                   RegWrite,
  output logic                   instr_done,
  output logic                   illegal_instr,
  output logic [STATE_WIDTH-1:0] state
);

  localparam logic [STATE_WIDTH-1:0] S_FETCH    = STATE_WIDTH'(0);
  localparam logic [STATE_WIDTH-1:0] S_DECODE   = STATE_WIDTH'(1);
  localparam logic [STATE_WIDTH-1:0] S_MEMADR   = STATE_WIDTH'(2);
  localparam logic [STATE_WIDTH-1:0] S_MEMREAD  = STATE_WIDTH'(3);
  localparam logic [STATE_WIDTH-1:0] S_MEMWB    = STATE_WIDTH'(4);
  localparam logic [STATE_WIDTH-1:0] S_MEMWRITE = STATE_WIDTH'(5);
  localparam logic [STATE_WIDTH-1:0] S_EXECUTER = STATE_WIDTH'(6);
  localparam logic [STATE_WIDTH-1:0] S_EXECUTEI = STATE_WIDTH'(7);
  localparam logic [STATE_WIDTH-1:0] S_ALUWB    = STATE_WIDTH'(8);
  localparam logic [STATE_WIDTH-1:0] S_BEQ      = STATE_WIDTH'(9);
  localparam logic [STATE_WIDTH-1:0] S_JAL      = STATE_WIDTH'(10);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [STATE_WIDTH-1:0] state_reg;
  logic [STATE_WIDTH-1:0] state_next;
  logic                   mem_ok;
  logic [2:0]             funct_alu;
  logic                   pc_write_next;
  logic                   mem_write_next;
  logic                   ir_write_next;
  logic                   reg_write_next;
  logic                   done_next;
  logic                   illegal_next;

  assign mem_ok = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // ALU operation for R-type and I-type execute; opcode[5] separates sub from addi
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (funct7b5 & opcode[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    state_next     = S_FETCH;
    AdrSrc         = 1'b0;
    ResultSrc      = 2'b00;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    ALUControl     = ALU_ADD;
    pc_write_next  = 1'b0;
    mem_write_next = 1'b0;
    ir_write_next  = 1'b0;
    reg_write_next = 1'b0;
    done_next      = 1'b0;
    illegal_next   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ALUSrcB       = 2'b10;
        ResultSrc     = 2'b10;
        ir_write_next = mem_ok;
        pc_write_next = mem_ok;
        state_next    = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default: begin
            state_next   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        AdrSrc         = 1'b1;
        mem_write_next = 1'b1;
        done_next      = mem_ok;
        state_next     = mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        ResultSrc      = 2'b01;
        reg_write_next = 1'b1;
        done_next      = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_next = 1'b1;
        done_next      = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA       = 2'b10;
        ALUControl    = ALU_SUB;
        pc_write_next = zero;
        done_next     = 1'b1;
      end
      S_JAL: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b10;
        pc_write_next = 1'b1;
        state_next    = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset is asynchronous, so enables are masked directly rather than waiting for an edge
  assign PCWrite       = pc_write_next  & ~rst;
  assign MemWrite      = mem_write_next & ~rst;
  assign IRWrite       = ir_write_next  & ~rst;
  assign RegWrite      = reg_write_next & ~rst;
  assign instr_done    = done_next      & ~rst;
  assign illegal_instr = illegal_next   & ~rst;
  assign state         = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle against hand-written state and control expectations.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0010011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  multicycle_control_fsm #(.STATE_WIDTH(4), .USE_MEM_READY(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .instr_done(instr_done), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge, drive mem_ready, let outputs settle
  task automatic cycle(input logic mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1);
      tests++;
      if (state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0 ||
          MemWrite !== 1'b0 || instr_done !== 1'b0 || illegal_instr !== 1'b0) begin
        fails++;
        $display("FAIL reset: state=%0d IR=%b PC=%b RW=%b MW=%b done=%b ill=%b, want state 0 all enables 0",
                 state, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr);
      end
      tests++;
      if (ALUSrcA !== 2'b00 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10 || AdrSrc !== 1'b0) begin
        fails++;
        $display("FAIL reset_selects: A=%b B=%b Res=%b Adr=%b, want 00 10 10 0",
                 ALUSrcA, ALUSrcB, ResultSrc, AdrSrc);
      end
    end
    mem_ready = 1'b0;
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_addi;
    int st[5] = '{0, 1, 7, 8, 0};
    logic mr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int done_cnt = 0;
    opcode = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, st[i]);
      end
      tests++;
      if (RegWrite !== (st[i] == 8)) begin
        fails++;
        $display("FAIL addi_regwrite[%0d]: got %b want %b", i, RegWrite, (st[i] == 8));
      end
      if (instr_done === 1'b1) done_cnt++;
      if (i == 0) begin
        tests++;
        if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
          fails++;
          $display("FAIL addi_fetch_en: IR=%b PC=%b want 1 1", IRWrite, PCWrite);
        end
      end
      if (i == 1) begin
        tests++;
        if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000) begin
          fails++;
          $display("FAIL addi_decode_sel: A=%b B=%b alu=%b want 01 01 000", ALUSrcA, ALUSrcB, ALUControl);
        end
      end
      if (i == 2) begin
        tests++;
        if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01 || ALUControl !== 3'b000) begin
          fails++;
          $display("FAIL addi_exec_sel: A=%b B=%b alu=%b want 10 01 000", ALUSrcA, ALUSrcB, ALUControl);
        end
      end
    end
    tests++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL addi_done_count: got %0d want 1", done_cnt);
    end
    $display("[TB] addi sequence complete");
  endtask

  task automatic test_lw;
    int st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 8; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, st[i]);
      end
      tests++;
      if (MemWrite !== 1'b0) begin
        fails++;
        $display("FAIL lw_memwrite[%0d]: got %b want 0", i, MemWrite);
      end
      if (st[i] == 3) begin
        tests++;
        if (AdrSrc !== 1'b1 || ResultSrc !== 2'b00 || RegWrite !== 1'b0) begin
          fails++;
          $display("FAIL lw_memread[%0d]: Adr=%b Res=%b RW=%b want 1 00 0", i, AdrSrc, ResultSrc, RegWrite);
        end
      end
      if (st[i] == 4) begin
        tests++;
        if (ResultSrc !== 2'b01 || RegWrite !== 1'b1 || instr_done !== 1'b1) begin
          fails++;
          $display("FAIL lw_memwb: Res=%b RW=%b done=%b want 01 1 1", ResultSrc, RegWrite, instr_done);
        end
      end
    end
    $display("[TB] lw sequence complete");
  endtask

  task automatic test_sw;
    int st[6] = '{0, 1, 2, 5, 5, 0};
    logic mr[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    opcode = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, st[i]);
      end
      tests++;
      if (MemWrite !== (st[i] == 5) || RegWrite !== 1'b0 || ImmSrc !== 2'b01) begin
        fails++;
        $display("FAIL sw_ctrl[%0d]: MW=%b RW=%b imm=%b want %b 0 01", i, MemWrite, RegWrite, ImmSrc, (st[i] == 5));
      end
      tests++;
      if (instr_done !== (i == 4)) begin
        fails++;
        $display("FAIL sw_done[%0d]: got %b want %b", i, instr_done, (i == 4));
      end
    end
    $display("[TB] sw sequence complete");
  endtask

  task automatic test_beq(input logic z);
    int st[4] = '{0, 1, 9, 0};
    logic mr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b1100011; funct3 = 3'b000; zero = z;
    for (int i = 0; i < 4; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL beq%0b_state[%0d]: got %0d want %0d", z, i, state, st[i]);
      end
      if (i == 2) begin
        tests++;
        if (PCWrite !== z || ALUControl !== 3'b001 || ImmSrc !== 2'b10 || instr_done !== 1'b1) begin
          fails++;
          $display("FAIL beq%0b_ctrl: PC=%b alu=%b imm=%b done=%b want %b 001 10 1",
                   z, PCWrite, ALUControl, ImmSrc, instr_done, z);
        end
      end
    end
    zero = 1'b0;
    $display("[TB] beq zero=%0b sequence complete", z);
  endtask

  task automatic test_funct(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic [2:0] want_alu, input int exec_state);
    int st[5] = '{0, 1, exec_state, 8, 0};
    logic mr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = op; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < 5; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL funct_state op=%b f3=%b [%0d]: got %0d want %0d", op, f3, i, state, st[i]);
      end
      if (i == 2) begin
        tests++;
        if (ALUControl !== want_alu) begin
          fails++;
          $display("FAIL funct_alu op=%b f3=%b f7=%b: got %b want %b", op, f3, f7, ALUControl, want_alu);
        end
      end
    end
    funct7b5 = 1'b0;
    $display("[TB] op=%b funct3=%b funct7b5=%b sequence complete", op, f3, f7);
  endtask

  task automatic test_jal;
    int st[5] = '{0, 1, 10, 8, 0};
    logic mr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b1101111;
    for (int i = 0; i < 5; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0] || ImmSrc !== 2'b11) begin
        fails++;
        $display("FAIL jal_state[%0d]: state=%0d imm=%b want %0d 11", i, state, ImmSrc, st[i]);
      end
      if (i == 2) begin
        tests++;
        if (PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10 || RegWrite !== 1'b0) begin
          fails++;
          $display("FAIL jal_ctrl: PC=%b A=%b B=%b RW=%b want 1 01 10 0", PCWrite, ALUSrcA, ALUSrcB, RegWrite);
        end
      end
    end
    $display("[TB] jal sequence complete");
  endtask

  task automatic test_illegal;
    int st[3] = '{0, 1, 0};
    logic mr[3] = '{1'b1, 1'b1, 1'b0};
    opcode = 7'b0000000;
    for (int i = 0; i < 3; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0] || illegal_instr !== (i == 1)) begin
        fails++;
        $display("FAIL illegal[%0d]: state=%0d ill=%b want %0d %b", i, state, illegal_instr, st[i], (i == 1));
      end
    end
    $display("[TB] illegal opcode sequence complete");
  endtask

  task automatic test_reset_in_memwrite;
    int st[4] = '{0, 1, 2, 5};
    logic mr[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      cycle(mr[i]);
      tests++;
      if (state !== st[i][3:0]) begin
        fails++;
        $display("FAIL rstmw_state[%0d]: got %0d want %0d", i, state, st[i]);
      end
    end
    tests++;
    if (MemWrite !== 1'b1) begin
      fails++;
      $display("FAIL rstmw_pre: MemWrite=%b want 1", MemWrite);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    tests++;
    if (MemWrite !== 1'b0 || state !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
      fails++;
      $display("FAIL rstmw_abort: MW=%b state=%0d IR=%b PC=%b want 0 0 0 0", MemWrite, state, IRWrite, PCWrite);
    end
    cycle(1'b1);
    mem_ready = 1'b0;
    rst = 1'b0;
    cycle(1'b0);
    tests++;
    if (state !== 4'd0 || MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL rstmw_after: state=%0d MW=%b want 0 0", state, MemWrite);
    end
    $display("[TB] reset during MEMWRITE complete");
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_funct(7'b0110011, 3'b000, 1'b1, 3'b001, 6);
    test_funct(7'b0010011, 3'b000, 1'b1, 3'b000, 7);
    test_funct(7'b0110011, 3'b111, 1'b0, 3'b010, 6);
    test_funct(7'b0110011, 3'b010, 1'b0, 3'b101, 6);
    test_funct(7'b0010011, 3'b110, 1'b0, 3'b011, 7);
    test_jal();
    test_illegal();
    test_reset_in_memwrite();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
